// File: rtl/axi_rom_arbiter_pkg.sv
// Arbiter FSM encoding, captured read-address record and grant index sizing.
// The grant index is sized from the requester count so N=2 still gets one bit.
package axi_rom_arbiter_pkg;

  import ravenoc_pkg::*;

  localparam int MAX_MASTERS = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA
  } arb_state_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } ar_capture_t;

  function automatic int grant_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int GRANT_IDX_W = grant_idx_w(MAX_MASTERS);

endpackage

// File: rtl/ravenoc_pkg.sv
// AXI4 read/write channel bundles shared by the NoC and its peripherals.
// mosi carries master-to-slave signals, miso carries slave-to-master signals.
package ravenoc_pkg;

  localparam int AXI_ID_W   = 4;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_USER_W = 4;

  typedef struct packed {
    logic [AXI_ID_W-1:0]     awid;
    logic [AXI_ADDR_W-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic [AXI_DATA_W-1:0]   wdata;
    logic [AXI_DATA_W/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    bready;
    logic [AXI_ID_W-1:0]     arid;
    logic [AXI_ADDR_W-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    rready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic                  awready;
    logic                  wready;
    logic [AXI_ID_W-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  arready;
    logic [AXI_ID_W-1:0]   rid;
    logic [AXI_DATA_W-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic [AXI_USER_W-1:0] ruser;
    logic                  rvalid;
  } s_axi_miso_t;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority picker: the lowest requester at or above i_ptr wins,
// otherwise the search wraps to the lowest requester overall.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant
);

  logic [N-1:0] w_upper;
  logic [N-1:0] w_sel;

  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    w_upper = '0;
    for (int i = 0; i < N; i++) begin
      w_upper[i] = i_req[i] && (IDX_W'(i) >= i_ptr);
    end
    w_sel   = (|w_upper) ? w_upper : i_req;
    o_grant = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_sel[i]) begin
        o_grant    = '0;
        o_grant[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_rom_arbiter.sv
// Funnels N AXI read requesters onto one ROM slave, one transaction at a time.
// Write channels are never acknowledged; the ROM is read-only.
module axi_rom_arbiter
  import ravenoc_pkg::*;
  import axi_rom_arbiter_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int RR_EN     = 1
) (
  input  logic        clk,
  input  logic        arst,
  input  s_axi_mosi_t slv_mosi_i [N_MASTERS],
  output s_axi_miso_t slv_miso_o [N_MASTERS],
  output s_axi_mosi_t rom_mosi_o,
  input  s_axi_miso_t rom_miso_i,
  output logic        busy_o
);

  localparam int IDX_W = grant_idx_w(N_MASTERS);

  arb_state_t       r_state;
  logic [IDX_W-1:0] r_grant;
  logic [IDX_W-1:0] r_prio_ptr;
  ar_capture_t      r_ar;

  logic [N_MASTERS-1:0] w_req;
  logic [N_MASTERS-1:0] w_grant;
  logic [IDX_W-1:0]     w_win_idx;
  logic [IDX_W-1:0]     w_arb_ptr;
  logic [IDX_W-1:0]     w_next_ptr;
  ar_capture_t          w_win_ar;
  logic                 w_sel_rready;
  logic                 w_live;
  logic                 w_unused;

  always_comb begin
    w_req = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      w_req[i] = slv_mosi_i[i].arvalid;
    end
  end

  assign w_arb_ptr  = (RR_EN != 0) ? r_prio_ptr : '0;
  assign w_next_ptr = (w_win_idx == IDX_W'(N_MASTERS - 1)) ? '0 : w_win_idx + 1'b1;
  assign w_live     = !arst;

  rr_arbiter #(
    .N     (N_MASTERS),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .i_req   (w_req),
    .i_ptr   (w_arb_ptr),
    .o_grant (w_grant)
  );

  always_comb begin
    w_win_idx    = '0;
    w_win_ar     = '0;
    w_sel_rready = 1'b0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (w_grant[i]) begin
        w_win_idx = IDX_W'(i);
        w_win_ar  = '{id:    slv_mosi_i[i].arid,
                      addr:  slv_mosi_i[i].araddr,
                      len:   slv_mosi_i[i].arlen,
                      size:  slv_mosi_i[i].arsize,
                      burst: slv_mosi_i[i].arburst};
      end
      if (IDX_W'(i) == r_grant) begin
        w_sel_rready = slv_mosi_i[i].rready;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every branch reads pre-edge state.
    if (arst) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_prio_ptr <= '0;
      r_ar       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_req) begin
            r_grant    <= w_win_idx;
            r_ar       <= w_win_ar;
            r_prio_ptr <= w_next_ptr;
            r_state    <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (rom_miso_i.arready) r_state <= ST_DATA;
        end
        ST_DATA: begin
          if (rom_miso_i.rvalid && w_sel_rready && rom_miso_i.rlast) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Handshakes are gated by reset so nothing leaks while arst is high.
  always_comb begin
    for (int i = 0; i < N_MASTERS; i++) begin
      slv_miso_o[i] = '0;
      if (w_live && r_state == ST_IDLE) begin
        slv_miso_o[i].arready = w_grant[i];
      end
      if (w_live && r_state == ST_DATA && IDX_W'(i) == r_grant) begin
        slv_miso_o[i].rid    = r_ar.id;
        slv_miso_o[i].rdata  = rom_miso_i.rdata;
        slv_miso_o[i].rresp  = rom_miso_i.rresp;
        slv_miso_o[i].rlast  = rom_miso_i.rlast;
        slv_miso_o[i].ruser  = rom_miso_i.ruser;
        slv_miso_o[i].rvalid = rom_miso_i.rvalid;
      end
    end
  end

  always_comb begin
    rom_mosi_o = '0;
    if (w_live && r_state == ST_ADDR) begin
      rom_mosi_o.arid    = r_ar.id;
      rom_mosi_o.araddr  = r_ar.addr;
      rom_mosi_o.arlen   = r_ar.len;
      rom_mosi_o.arsize  = r_ar.size;
      rom_mosi_o.arburst = r_ar.burst;
      rom_mosi_o.arvalid = 1'b1;
    end
    if (w_live && r_state == ST_DATA) begin
      rom_mosi_o.rready = w_sel_rready;
    end
  end

  assign busy_o = w_live && (r_state != ST_IDLE);

  always_comb begin
    w_unused = ^{rom_miso_i.awready, rom_miso_i.wready, rom_miso_i.bid,
                 rom_miso_i.bresp, rom_miso_i.bvalid, rom_miso_i.rid};
    for (int i = 0; i < N_MASTERS; i++) begin
      w_unused = w_unused ^ (^{slv_mosi_i[i].awid, slv_mosi_i[i].awaddr, slv_mosi_i[i].awlen,
                               slv_mosi_i[i].awsize, slv_mosi_i[i].awburst, slv_mosi_i[i].awvalid,
                               slv_mosi_i[i].wdata, slv_mosi_i[i].wstrb, slv_mosi_i[i].wlast,
                               slv_mosi_i[i].wvalid, slv_mosi_i[i].bready});
    end
  end

endmodule

// File: tb/tb_axi_rom_arbiter.sv
// Directed bench: a 2-port round-robin arbiter with a scripted ROM slave, plus
// a 4-port fixed-priority instance; R beats are matched against a scoreboard.
module tb_axi_rom_arbiter;
  import ravenoc_pkg::*;

  logic clk  = 1'b0;
  logic arst = 1'b1;
  always #5 clk = ~clk;

  s_axi_mosi_t mosi_a [2];
  s_axi_miso_t miso_a [2];
  s_axi_mosi_t rom_mosi_a;
  s_axi_miso_t rom_miso_a;
  logic        busy_a;

  s_axi_mosi_t mosi_b [4];
  s_axi_miso_t miso_b [4];
  s_axi_mosi_t rom_mosi_b;
  s_axi_miso_t rom_miso_b;
  logic        busy_b;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int          port;
    logic [3:0]  id;
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t sb_q [$];

  axi_rom_arbiter #(.N_MASTERS(2), .RR_EN(1)) dut (
    .clk        (clk),
    .arst       (arst),
    .slv_mosi_i (mosi_a),
    .slv_miso_o (miso_a),
    .rom_mosi_o (rom_mosi_a),
    .rom_miso_i (rom_miso_a),
    .busy_o     (busy_a)
  );

  axi_rom_arbiter #(.N_MASTERS(4), .RR_EN(0)) dut_fp (
    .clk        (clk),
    .arst       (arst),
    .slv_mosi_i (mosi_b),
    .slv_miso_o (miso_b),
    .rom_mosi_o (rom_mosi_b),
    .rom_miso_i (rom_miso_b),
    .busy_o     (busy_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [31:0] rom_data(input logic [31:0] addr, input int beat);
    return (addr * 32'd3) + 32'hC0DE_0000 + 32'(beat);
  endfunction

  function automatic logic [1:0] oh2(input int p);
    return 2'b01 << p;
  endfunction

  function automatic logic [1:0] arready_a();
    return {miso_a[1].arready, miso_a[0].arready};
  endfunction

  function automatic logic [1:0] rvalid_a();
    return {miso_a[1].rvalid, miso_a[0].rvalid};
  endfunction

  function automatic logic [3:0] arready_b();
    return {miso_b[3].arready, miso_b[2].arready, miso_b[1].arready, miso_b[0].arready};
  endfunction

  function automatic logic [3:0] rvalid_b();
    return {miso_b[3].rvalid, miso_b[2].rvalid, miso_b[1].rvalid, miso_b[0].rvalid};
  endfunction

  function automatic logic wr_activity_a();
    return |{miso_a[0].awready, miso_a[0].wready, miso_a[0].bvalid,
             miso_a[1].awready, miso_a[1].wready, miso_a[1].bvalid,
             rom_mosi_a.awvalid, rom_mosi_a.wvalid};
  endfunction

  task automatic issue_a(input int port, input logic [31:0] addr, input logic [3:0] id,
                         input logic [7:0] len);
    mosi_a[port].araddr  = addr;
    mosi_a[port].arid    = id;
    mosi_a[port].arlen   = len;
    mosi_a[port].arsize  = 3'd2;
    mosi_a[port].arburst = 2'b01;
    mosi_a[port].arvalid = 1'b1;
  endtask

  // Waits for the IDLE-cycle acknowledge and drops arvalid once it is taken.
  task automatic wait_grant_a(input int port, input string tag);
    bit got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      #1;
      if (arready_a() != 2'b00) got = 1'b1;
      else tick();
    end
    check({tag, "_seen"}, 64'(got), 64'(1));
    if (got) begin
      check({tag, "_port"}, 64'(arready_a()), 64'(oh2(port)));
      tick();
      mosi_a[port].arvalid = 1'b0;
    end
  endtask

  // Plays the ROM slave: accepts the AR after ar_delay cycles, then returns
  // nbeats beats; bp_cycles of requester backpressure are applied on beat 0.
  task automatic serve_rom_a(input int port, input logic [31:0] addr, input logic [3:0] id,
                             input int nbeats, input int ar_delay, input int bp_cycles,
                             input string tag);
    bit          got = 1'b0;
    int          wait_c = 0;
    int          obs_port;
    beat_t       exp_b;
    beat_t       pop_b;
    logic [1:0]  rv;
    for (int c = 0; c < 40 && !got; c++) begin
      #1;
      if (rom_mosi_a.arvalid) got = 1'b1;
      else begin
        wait_c++;
        tick();
      end
    end
    check({tag, "_ar_seen"}, 64'(got), 64'(1));
    if (!got) return;
    check({tag, "_ar_latency"}, 64'(wait_c), 64'(0));
    check({tag, "_ar_addr"}, 64'(rom_mosi_a.araddr), 64'(addr));
    check({tag, "_ar_id"}, 64'(rom_mosi_a.arid), 64'(id));
    check({tag, "_ar_len"}, 64'(rom_mosi_a.arlen), 64'(nbeats - 1));
    check({tag, "_busy_addr"}, 64'(busy_a), 64'(1));
    for (int k = 0; k < ar_delay; k++) begin
      rom_miso_a.rvalid = 1'b1;
      rom_miso_a.rdata  = 32'hDEAD_BEEF;
      tick();
      #1;
      check({tag, "_ar_hold"}, 64'({rom_mosi_a.arvalid, rom_mosi_a.araddr}), 64'({1'b1, addr}));
      check({tag, "_stray_rvalid"}, 64'(rvalid_a()), 64'(0));
    end
    rom_miso_a.rvalid  = 1'b0;
    rom_miso_a.arready = 1'b1;
    tick();
    rom_miso_a.arready = 1'b0;
    for (int bi = 0; bi < nbeats; bi++) begin
      rom_miso_a.rvalid = 1'b1;
      rom_miso_a.rdata  = rom_data(addr, bi);
      rom_miso_a.rlast  = (bi == nbeats - 1);
      rom_miso_a.rresp  = 2'b00;
      rom_miso_a.ruser  = 4'(bi);
      exp_b = '{port: port, id: id, data: rom_data(addr, bi), last: (bi == nbeats - 1)};
      sb_q.push_back(exp_b);
      if (bi == 0 && bp_cycles > 0) begin
        mosi_a[port].rready = 1'b0;
        for (int k = 0; k < bp_cycles; k++) begin
          #1;
          check({tag, "_bp_rdata"}, 64'(miso_a[port].rdata), 64'(rom_data(addr, 0)));
          check({tag, "_bp_busy"}, 64'(busy_a), 64'(1));
          check({tag, "_bp_no_grant"}, 64'(arready_a()), 64'(0));
          check({tag, "_bp_rom_rready"}, 64'(rom_mosi_a.rready), 64'(0));
          tick();
        end
        mosi_a[port].rready = 1'b1;
      end
      #1;
      rv = rvalid_a();
      check({tag, "_rvalid_onehot"}, 64'(rv), 64'(oh2(port)));
      if (rv != 2'b00 && sb_q.size() > 0) begin
        pop_b    = sb_q.pop_front();
        obs_port = rv[1] ? 1 : 0;
        check({tag, "_r_port"}, 64'(obs_port), 64'(pop_b.port));
        check({tag, "_rid"}, 64'(miso_a[obs_port].rid), 64'(pop_b.id));
        check({tag, "_rdata"}, 64'(miso_a[obs_port].rdata), 64'(pop_b.data));
        check({tag, "_rlast"}, 64'(miso_a[obs_port].rlast), 64'(pop_b.last));
      end
      check({tag, "_rom_rready"}, 64'(rom_mosi_a.rready), 64'(1));
      check({tag, "_wr_quiet"}, 64'(wr_activity_a()), 64'(0));
      tick();
    end
    rom_miso_a.rvalid = 1'b0;
    rom_miso_a.rlast  = 1'b0;
    #1;
    check({tag, "_done_idle"}, 64'(busy_a), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int grants;
    bit got;
    for (int i = 0; i < 2; i++) begin
      mosi_a[i]        = '0;
      mosi_a[i].rready = 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      mosi_b[i]        = '0;
      mosi_b[i].rready = 1'b1;
    end
    rom_miso_a = '0;
    rom_miso_b = '0;

    // Reset: requests and stray ROM beats must be masked while arst is high.
    arst                = 1'b1;
    mosi_a[0].arvalid   = 1'b1;
    rom_miso_a.rvalid   = 1'b1;
    #1;
    check("rst_pre_edge_arready", 64'(arready_a()), 64'(0));
    tick();
    #1;
    check("rst_busy", 64'(busy_a), 64'(0));
    check("rst_arready", 64'(arready_a()), 64'(0));
    check("rst_rvalid", 64'(rvalid_a()), 64'(0));
    check("rst_rom_arvalid", 64'(rom_mosi_a.arvalid), 64'(0));
    check("rst_rlast", 64'({miso_a[1].rlast, miso_a[0].rlast}), 64'(0));
    tick();
    mosi_a[0].arvalid = 1'b0;
    arst              = 1'b0;
    #1;
    check("post_rst_idle_stray_rvalid", 64'(rvalid_a()), 64'(0));
    check("post_rst_busy", 64'(busy_a), 64'(0));
    rom_miso_a.rvalid = 1'b0;
    tick();

    // Single read from port 0.
    issue_a(0, 32'h0000_0010, 4'd3, 8'd0);
    wait_grant_a(0, "single_grant");
    serve_rom_a(0, 32'h0000_0010, 4'd3, 1, 0, 0, "single");

    // Contention from reset: 0 wins, then 1 (pointer wraps), then 0 again.
    arst = 1'b1;
    tick();
    arst = 1'b0;
    issue_a(0, 32'h0000_0100, 4'd1, 8'd0);
    issue_a(1, 32'h0000_0200, 4'd2, 8'd0);
    wait_grant_a(0, "cont_first");
    serve_rom_a(0, 32'h0000_0100, 4'd1, 1, 2, 0, "cont0");
    issue_a(0, 32'h0000_0104, 4'd5, 8'd2);
    wait_grant_a(1, "cont_second");
    serve_rom_a(1, 32'h0000_0200, 4'd2, 1, 0, 0, "cont1");
    wait_grant_a(0, "cont_third");
    serve_rom_a(0, 32'h0000_0104, 4'd5, 3, 1, 0, "cont0b");

    // Requester backpressure while another port waits.
    issue_a(1, 32'h0000_0300, 4'd9, 8'd1);
    wait_grant_a(1, "bp_grant");
    issue_a(0, 32'h0000_0310, 4'd7, 8'd0);
    serve_rom_a(1, 32'h0000_0300, 4'd9, 2, 1, 5, "bp");
    wait_grant_a(0, "bp_waiter");
    serve_rom_a(0, 32'h0000_0310, 4'd7, 1, 0, 0, "bp_after");

    // Reset while a beat is pending in DATA.
    issue_a(0, 32'h0000_0400, 4'd4, 8'd0);
    wait_grant_a(0, "rstmid_grant");
    rom_miso_a.arready = 1'b1;
    tick();
    rom_miso_a.arready  = 1'b0;
    mosi_a[0].rready    = 1'b0;
    rom_miso_a.rvalid   = 1'b1;
    rom_miso_a.rdata    = 32'h1234_5678;
    rom_miso_a.rlast    = 1'b1;
    #1;
    check("rstmid_pending_rvalid", 64'(rvalid_a()), 64'(oh2(0)));
    arst = 1'b1;
    #1;
    check("rstmid_during_rvalid", 64'(rvalid_a()), 64'(0));
    check("rstmid_during_busy", 64'(busy_a), 64'(0));
    tick();
    arst             = 1'b0;
    mosi_a[0].rready = 1'b1;
    #1;
    check("rstmid_after_rvalid", 64'(rvalid_a()), 64'(0));
    check("rstmid_after_busy", 64'(busy_a), 64'(0));
    check("rstmid_after_rom_rready", 64'(rom_mosi_a.rready), 64'(0));
    check("rstmid_after_rom_arvalid", 64'(rom_mosi_a.arvalid), 64'(0));
    tick();
    rom_miso_a.rvalid = 1'b0;
    rom_miso_a.rlast  = 1'b0;
    issue_a(1, 32'h0000_0500, 4'd6, 8'd1);
    wait_grant_a(1, "rstmid_new_grant");
    serve_rom_a(1, 32'h0000_0500, 4'd6, 2, 0, 0, "rstmid_new");

    // Write attempt held on port 0 across idle time and two reads.
    mosi_a[0].awvalid = 1'b1;
    mosi_a[0].awaddr  = 32'h0000_0800;
    mosi_a[0].wvalid  = 1'b1;
    mosi_a[0].wdata   = 32'hFFFF_0000;
    mosi_a[0].wlast   = 1'b1;
    mosi_a[0].bready  = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("wr_idle_quiet", 64'(wr_activity_a()), 64'(0));
      tick();
    end
    issue_a(1, 32'h0000_0600, 4'd10, 8'd0);
    wait_grant_a(1, "wr_rd1_grant");
    serve_rom_a(1, 32'h0000_0600, 4'd10, 1, 0, 0, "wr_rd1");
    issue_a(0, 32'h0000_0604, 4'd11, 8'd1);
    wait_grant_a(0, "wr_rd2_grant");
    serve_rom_a(0, 32'h0000_0604, 4'd11, 2, 1, 0, "wr_rd2");
    for (int k = 0; k < 8; k++) begin
      #1;
      check("wr_tail_quiet", 64'(wr_activity_a()), 64'(0));
      tick();
    end
    mosi_a[0].awvalid = 1'b0;
    mosi_a[0].wvalid  = 1'b0;
    check("sb_drained", 64'(sb_q.size()), 64'(0));

    // Fixed priority on the 4-port instance: port 1 beats port 3 every time.
    rom_miso_b.arready = 1'b1;
    rom_miso_b.rvalid  = 1'b1;
    rom_miso_b.rlast   = 1'b1;
    rom_miso_b.rdata   = 32'h0BAD_F00D;
    mosi_b[1].arid     = 4'd1;
    mosi_b[1].araddr   = 32'h0000_0010;
    mosi_b[1].arvalid  = 1'b1;
    mosi_b[3].arid     = 4'd3;
    mosi_b[3].araddr   = 32'h0000_0030;
    mosi_b[3].arvalid  = 1'b1;
    grants = 0;
    for (int k = 0; k < 15; k++) begin
      #1;
      if (arready_b() != 4'b0000) begin
        grants++;
        check("fp_grant_port1", 64'(arready_b()), 64'(4'b0010));
      end
      if (rvalid_b() != 4'b0000) begin
        check("fp_rvalid_port1", 64'(rvalid_b()), 64'(4'b0010));
        check("fp_rid", 64'(miso_b[1].rid), 64'(1));
      end
      tick();
    end
    check("fp_grant_count", 64'(grants >= 4), 64'(1));
    mosi_b[1].arvalid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      #1;
      if (arready_b() != 4'b0000) got = 1'b1;
      else tick();
    end
    check("fp_port3_seen", 64'(got), 64'(1));
    check("fp_port3_grant", 64'(arready_b()), 64'(4'b1000));
    tick();
    mosi_b[3].arvalid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi_rom_arbiter.md
AXI_ROM_ARBITER -- requirements
Module: axi_rom_arbiter

Interface
REQ-001 Parameter N_MASTERS, default 2, number of requester ports (legal 2..8).
REQ-002 Parameter RR_EN, default 1, 1 = round-robin, 0 = fixed priority (lowest index wins).
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 arst  input  1  reset; synchronous, active-high; sampled only on posedge clk.
REQ-005 slv_mosi_i  input  s_axi_mosi_t [N_MASTERS]  requester AXI master-to-slave channels.
REQ-006 slv_miso_o  output  s_axi_miso_t [N_MASTERS]  requester AXI slave-to-master channels.
REQ-007 rom_mosi_o  output  s_axi_mosi_t  shared downstream port to the ROM AXI slave.
REQ-008 rom_miso_i  input  s_axi_miso_t  shared downstream response channels.
REQ-009 busy_o  output  1  high whenever the FSM is not IDLE.

Function
REQ-010 FSM states: IDLE, ADDR, DATA.
REQ-011 IDLE: if any slv_mosi_i[i].arvalid, select one winner, assert slv_miso_o[win].arready for that cycle, capture araddr/arid/arlen/arsize/arburst, store win in grant_ff, go to ADDR.
REQ-012 IDLE with no arvalid: stay in IDLE; all arready low.
REQ-013 Round-robin: search starts at prio_ptr; on grant, prio_ptr <= win+1 modulo N_MASTERS (wrap N_MASTERS-1 -> 0).
REQ-014 ADDR: rom_mosi_o.arvalid=1 with captured fields; on rom_miso_i.arready go to DATA; hold fields stable while arready low.
REQ-015 DATA: rom_miso_i R channel (rdata, rresp, rlast, ruser, rvalid) routed combinationally to slv_miso_o[grant_ff] only; rid driven with captured arid; rom_mosi_o.rready = slv_mosi_i[grant_ff].rready.
REQ-016 DATA exit: rvalid && rready && rlast -> IDLE; a beat without rlast stays in DATA (bursts pass through unchanged).
REQ-017 Non-granted ports: rvalid=0 and arready=0 at all times outside their grant cycle.
REQ-018 Latency: requester arvalid sampled in IDLE at cycle T -> downstream arvalid at T+1 -> earliest DATA at T+2; minimum gap between back-to-back grants is 1 IDLE cycle.
REQ-019 Write channels: awready, wready, bvalid held 0 on every slv_miso_o; rom_mosi_o awvalid and wvalid held 0.
REQ-020 Simultaneous requests: exactly one grant per IDLE cycle; losers keep arvalid and are served in later transactions.
REQ-021 Request arriving while busy: not acknowledged until FSM returns to IDLE.
REQ-022 rvalid arriving from ROM in IDLE or ADDR: ignored and not forwarded.
REQ-023 All unused miso/mosi fields driven 0.

Reset
REQ-024 On arst: state=IDLE, grant_ff=0, prio_ptr=0, captured AR fields=0.
REQ-025 Outputs during and after reset: every arready/rvalid/rlast low, rom_mosi_o.arvalid=0, busy_o=0.
REQ-026 Reset asserted in ADDR or DATA aborts the transaction at the next edge; no R beat is forwarded afterwards.

Structure
REQ-027 s_axi_mosi_t / s_axi_miso_t are taken from ravenoc_pkg; an arb_state_t enum and a grant-index width constant (clog2 of N_MASTERS) live in the shared misc package.
REQ-028 One sub-module rr_arbiter (request vector, pointer -> one-hot grant) is instantiated; FSM and muxing stay in axi_rom_arbiter.

Verification
REQ-029 Single read: master 0 reads araddr 0x0000_0010 arid 3 -> one ROM AR with addr 0x10, R beat to port 0 with rid 3, rlast 1; port 1 never sees rvalid.
REQ-030 Contention: ports 0 and 1 assert arvalid in the same cycle from reset -> port 0 granted first, port 1 second; repeat -> port 1 then port 0 (pointer wrap).
REQ-031 Fixed priority (RR_EN=0, N_MASTERS=4): ports 1 and 3 continuously request -> port 1 always wins while requesting.
REQ-032 Backpressure: requester holds rready=0 for 5 cycles -> rdata stable, FSM stays in DATA, busy_o=1, no other grant occurs.
REQ-033 Reset mid-DATA: arst asserted while rvalid is pending -> next cycle IDLE, all outputs at reset values, a new read completes normally.
REQ-034 Write attempt: awvalid/wvalid held on port 0 for 20 cycles -> awready, wready, bvalid stay 0; interleaved reads complete.
